// File: rtl/gigerx_byte_packer.sv
// -----------------------------------------------------------------------------
// gigerx_byte_packer
//
// Packs the 8-bit receive byte stream from the gigabit MAC front end into
// 64-bit words for the RX FIFO write port. The first byte of each word lands
// in [63:56]. Per-frame status is reported on a one-cycle strobe.
//
// Parameters:
//   MAX_LEN      saturation value for frame_len (must be <= 16383)
//
// Ports:
//   clk          single clock, shared with the FIFO write side
//   srst         synchronous active-high reset
//   rx_dv        byte valid, high and contiguous for the whole frame
//   rxd[7:0]     receive byte, sampled when rx_dv=1
//   rx_er        receive error, sampled when rx_dv=1
//   full         FIFO full flag
//   wrreq        FIFO write strobe (registered, one cycle)
//   data[63:0]   FIFO write word (registered)
//   frame_done   one-cycle end-of-frame strobe
//   frame_len    bytes in the frame, saturating at MAX_LEN
//   last_bytes   valid bytes in the final word (0 means 8)
//   frame_err    rx_er was seen during the frame
//   frame_drop   one or more words of the frame were lost to full
//
// Write handshake: wrreq is a single-cycle strobe with no back-pressure
// acknowledge. The decision to write is made in the cycle that samples the
// completing byte (or the frame end), using full as sampled in that same
// cycle; wrreq then appears on the following cycle with the word on data.
// A word refused by full is discarded, never retried.
// -----------------------------------------------------------------------------
module gigerx_byte_packer #(
    parameter int MAX_LEN = 16383
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        rx_dv,
    input  logic [7:0]  rxd,
    input  logic        rx_er,
    input  logic        full,
    output logic        wrreq,
    output logic [63:0] data,
    output logic        frame_done,
    output logic [13:0] frame_len,
    output logic [2:0]  last_bytes,
    output logic        frame_err,
    output logic        frame_drop
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        PACK      = 2'd2,
        DROP      = 2'd3
    } state_t;

    localparam logic [13:0] MAX_LEN_W = 14'(MAX_LEN);

    // FSM state
    state_t state, state_next;

    // Frame working registers
    logic [63:0] word_q,    word_next;
    logic [2:0]  byte_cnt,  byte_cnt_next;
    logic [13:0] len_cnt,   len_cnt_next;
    logic        err_q,     err_next;
    logic        drop_q,    drop_next;

    // Registered outputs, next values
    logic        wrreq_next;
    logic [63:0] data_next;
    logic        frame_done_next;
    logic [13:0] frame_len_next;
    logic [2:0]  last_bytes_next;
    logic        frame_err_next;
    logic        frame_drop_next;

    // Helpers
    logic [63:0] word_with_byte;
    logic [13:0] len_inc;

    // Insert rxd at lane byte_cnt; lane k occupies [63-8k:56-8k].
    always_comb begin
        word_with_byte = word_q;
        word_with_byte[{3'd7 - byte_cnt, 3'b000} +: 8] = rxd;
    end

    assign len_inc = (len_cnt >= MAX_LEN_W) ? len_cnt : len_cnt + 14'd1;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        word_next       = word_q;
        byte_cnt_next   = byte_cnt;
        len_cnt_next    = len_cnt;
        err_next        = err_q;
        drop_next       = drop_q;
        wrreq_next      = 1'b0;
        data_next       = data;
        frame_done_next = 1'b0;
        frame_len_next  = frame_len;
        last_bytes_next = last_bytes;
        frame_err_next  = frame_err;
        frame_drop_next = frame_drop;

        case (state)
            // A frame already running when reset releases is skipped whole.
            WAIT_IDLE: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                if (rx_dv) begin
                    word_next     = {rxd, 56'd0};
                    byte_cnt_next = 3'd1;
                    len_cnt_next  = 14'd1;
                    err_next      = rx_er;
                    drop_next     = 1'b0;
                    state_next    = PACK;
                end
            end

            PACK: begin
                if (rx_dv) begin
                    byte_cnt_next = byte_cnt + 3'd1;
                    len_cnt_next  = len_inc;
                    err_next      = err_q | rx_er;
                    if (byte_cnt == 3'd7) begin
                        // Clear the buffer so a later partial word carries
                        // zeros in its unused lanes.
                        word_next = 64'd0;
                        if (!full) begin
                            wrreq_next = 1'b1;
                            data_next  = word_with_byte;
                        end else begin
                            drop_next  = 1'b1;
                            state_next = DROP;
                        end
                    end else begin
                        word_next = word_with_byte;
                    end
                end else begin
                    frame_done_next = 1'b1;
                    frame_len_next  = len_cnt;
                    last_bytes_next = byte_cnt;
                    frame_err_next  = err_q;
                    frame_drop_next = drop_q;
                    if (byte_cnt != 3'd0) begin
                        if (!full) begin
                            wrreq_next = 1'b1;
                            data_next  = word_q;
                        end else begin
                            frame_drop_next = 1'b1;
                        end
                    end
                    state_next = IDLE;
                end
            end

            DROP: begin
                if (rx_dv) begin
                    byte_cnt_next = byte_cnt + 3'd1;
                    len_cnt_next  = len_inc;
                    err_next      = err_q | rx_er;
                end else begin
                    frame_done_next = 1'b1;
                    frame_len_next  = len_cnt;
                    last_bytes_next = byte_cnt;
                    frame_err_next  = err_q;
                    frame_drop_next = 1'b1;
                    state_next      = IDLE;
                end
            end

            default: begin
                state_next = WAIT_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= WAIT_IDLE;
            word_q     <= 64'd0;
            byte_cnt   <= 3'd0;
            len_cnt    <= 14'd0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            wrreq      <= 1'b0;
            data       <= 64'd0;
            frame_done <= 1'b0;
            frame_len  <= 14'd0;
            last_bytes <= 3'd0;
            frame_err  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            state      <= state_next;
            word_q     <= word_next;
            byte_cnt   <= byte_cnt_next;
            len_cnt    <= len_cnt_next;
            err_q      <= err_next;
            drop_q     <= drop_next;
            wrreq      <= wrreq_next;
            data       <= data_next;
            frame_done <= frame_done_next;
            frame_len  <= frame_len_next;
            last_bytes <= last_bytes_next;
            frame_err  <= frame_err_next;
            frame_drop <= frame_drop_next;
        end
    end

endmodule

// File: tb/tb_gigerx_byte_packer.sv
// -----------------------------------------------------------------------------
// Testbench for gigerx_byte_packer. Expected FIFO words and frame status are
// computed from the frame description when a frame is driven and queued; the
// monitor pops and compares them as the DUT produces wrreq / frame_done.
// -----------------------------------------------------------------------------
module tb_gigerx_byte_packer;

    localparam int MAX_LEN = 40;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        srst;
    logic        rx_dv;
    logic [7:0]  rxd;
    logic        rx_er;
    logic        full;
    logic        wrreq;
    logic [63:0] data;
    logic        frame_done;
    logic [13:0] frame_len;
    logic [2:0]  last_bytes;
    logic        frame_err;
    logic        frame_drop;

    always #5 clk = ~clk;

    gigerx_byte_packer #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .srst       (srst),
        .rx_dv      (rx_dv),
        .rxd        (rxd),
        .rx_er      (rx_er),
        .full       (full),
        .wrreq      (wrreq),
        .data       (data),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .last_bytes (last_bytes),
        .frame_err  (frame_err),
        .frame_drop (frame_drop)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int wr_cycle   = -1;
    int done_cycle = -1;
    int wr_count   = 0;
    int done_count = 0;

    logic [63:0] exp_q[$];
    logic [18:0] stat_q[$];   // {frame_len, last_bytes, frame_err, frame_drop}

    logic [63:0] exp_w;
    logic [18:0] exp_s;

    // Frame description used by drive_frame
    logic [7:0] f_byte [0:63];
    logic       f_er   [0:63];
    logic       f_full [0:64];

    always @(posedge clk) cycle++;

    // Monitor: compare each DUT write / status strobe against the queues
    always @(negedge clk) begin
        if (!srst) begin
            if (wrreq) begin
                wr_cycle = cycle;
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got data=%h, required no write", data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (data !== exp_w) begin
                        errors++;
                        $display("FAIL wr_data: got %h, required %h", data, exp_w);
                    end
                end
            end
            if (frame_done) begin
                done_cycle = cycle;
                done_count++;
                checks++;
                if (stat_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got len=%0d last=%0d err=%0d drop=%0d, required no frame_done",
                             frame_len, last_bytes, frame_err, frame_drop);
                end else begin
                    exp_s = stat_q.pop_front();
                    if ({frame_len, last_bytes, frame_err, frame_drop} !== exp_s) begin
                        errors++;
                        $display("FAIL status: got len=%0d last=%0d err=%0d drop=%0d, required len=%0d last=%0d err=%0d drop=%0d",
                                 frame_len, last_bytes, frame_err, frame_drop,
                                 exp_s[18:5], exp_s[4:2], exp_s[1], exp_s[0]);
                    end
                end
            end
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic clear_frame();
        for (int i = 0; i < 64; i++) begin
            f_byte[i] = 8'h00;
            f_er[i]   = 1'b0;
            f_full[i] = 1'b0;
        end
        f_full[64] = 1'b0;
    endtask

    // Queue the expected results for an n-byte frame, then drive it followed
    // by one idle cycle (full on that cycle taken from f_full[n]).
    task automatic drive_frame(input int n);
        logic [63:0] w;
        logic        dropped;
        logic        err;
        int          len;
        w       = 64'd0;
        dropped = 1'b0;
        err     = 1'b0;
        for (int i = 0; i < n; i++) begin
            w[(7 - (i % 8)) * 8 +: 8] = f_byte[i];
            err = err | f_er[i];
            if (i % 8 == 7) begin
                if (!dropped) begin
                    if (!f_full[i]) exp_q.push_back(w);
                    else            dropped = 1'b1;
                end
                w = 64'd0;
            end
        end
        if ((n % 8) != 0 && !dropped) begin
            if (!f_full[n]) exp_q.push_back(w);
            else            dropped = 1'b1;
        end
        len = (n > MAX_LEN) ? MAX_LEN : n;
        stat_q.push_back({14'(len), 3'(n % 8), err, dropped});

        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1;
            rxd   = f_byte[i];
            rx_er = f_er[i];
            full  = f_full[i];
        end
        @(posedge clk); #1;
        rx_dv = 1'b0;
        rxd   = 8'h00;
        rx_er = 1'b0;
        full  = f_full[n];
    endtask

    // Let the DUT finish, then confirm every expectation was consumed.
    task automatic drain();
        @(posedge clk); #1;
        full = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words and %0d status pending, required 0 and 0",
                     exp_q.size(), stat_q.size());
            exp_q.delete();
            stat_q.delete();
        end
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        srst  = 1'b1;
        rx_dv = 1'b0;
        rxd   = 8'h00;
        rx_er = 1'b0;
        full  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wrreq, data, frame_done, frame_len, last_bytes, frame_err, frame_drop} !== 84'd0) begin
            errors++;
            $display("FAIL reset_outputs: got wrreq=%0d data=%h done=%0d len=%0d last=%0d err=%0d drop=%0d, required all 0",
                     wrreq, data, frame_done, frame_len, last_bytes, frame_err, frame_drop);
        end
        @(posedge clk); #1;
        srst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_words();
        clear_frame();
        for (int i = 0; i < 16; i++) f_byte[i] = 8'(i);
        drive_frame(16);
        drain();
        checks++;
        if (done_cycle !== wr_cycle + 1) begin
            errors++;
            $display("FAIL full_words_timing: got done_cycle=%0d, required %0d", done_cycle, wr_cycle + 1);
        end
    endtask

    task automatic test_partial();
        clear_frame();
        for (int i = 0; i < 13; i++) f_byte[i] = 8'(i);
        drive_frame(13);
        drain();
        checks++;
        if (done_cycle !== wr_cycle) begin
            errors++;
            $display("FAIL partial_coincide: got wr_cycle=%0d, required %0d", wr_cycle, done_cycle);
        end
    endtask

    task automatic test_single_byte();
        clear_frame();
        f_byte[0] = 8'hAB;
        drive_frame(1);
        drain();
        checks++;
        if (done_cycle !== wr_cycle) begin
            errors++;
            $display("FAIL single_coincide: got wr_cycle=%0d, required %0d", wr_cycle, done_cycle);
        end
    endtask

    task automatic test_drop();
        int wr_before;
        clear_frame();
        for (int i = 0; i < 24; i++) f_byte[i] = 8'h20 + 8'(i);
        f_full[15] = 1'b1;
        wr_before = wr_count;
        drive_frame(24);
        drain();
        checks++;
        if (wr_count - wr_before !== 1) begin
            errors++;
            $display("FAIL drop_writes: got %0d writes, required 1", wr_count - wr_before);
        end
    endtask

    task automatic test_back_to_back();
        clear_frame();
        for (int i = 0; i < 10; i++) f_byte[i] = 8'h80 + 8'(i);
        f_er[2] = 1'b1;
        drive_frame(10);
        clear_frame();
        for (int i = 0; i < 9; i++) f_byte[i] = 8'h40 + 8'(i);
        drive_frame(9);
        drain();
    endtask

    task automatic test_saturation();
        clear_frame();
        for (int i = 0; i < 48; i++) f_byte[i] = 8'(8'hC0 ^ 8'(i));
        drive_frame(48);
        drain();
    endtask

    task automatic test_midframe_reset();
        int wr_before;
        int done_before;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rx_dv = 1'b1;
            rxd   = 8'h11 + 8'(i);
            @(posedge clk); #1;
        end
        srst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wrreq, data, frame_done, frame_len, last_bytes, frame_err, frame_drop} !== 84'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got wrreq=%0d data=%h done=%0d len=%0d, required all 0",
                     wrreq, data, frame_done, frame_len);
        end
        @(posedge clk); #1;
        srst        = 1'b0;
        wr_before   = wr_count;
        done_before = done_count;
        for (int i = 0; i < 10; i++) begin
            rxd = 8'h50 + 8'(i);
            @(posedge clk); #1;
        end
        rx_dv = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_count !== wr_before || done_count !== done_before) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d writes %0d done, required 0 and 0",
                     wr_count - wr_before, done_count - done_before);
        end
        clear_frame();
        for (int i = 0; i < 5; i++) f_byte[i] = 8'h70 + 8'(i);
        drive_frame(5);
        drain();
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 8; f++) begin
            clear_frame();
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) begin
                f_byte[i] = 8'($urandom_range(0, 255));
                f_er[i]   = ($urandom_range(0, 19) == 0);
            end
            for (int i = 0; i <= n; i++) f_full[i] = ($urandom_range(0, 5) == 0);
            drive_frame(n);
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_single_byte();
        test_drop();
        test_back_to_back();
        test_saturation();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
